// File: rtl/gmii_demux.sv
// GMII receive demultiplexer: forwards whole frames to one of three outputs chosen at frame start.
// Define GMII_DEMUX_FRAME_CNT_EN to build the per-port frame and drop counters.
module gmii_demux #(
  parameter int unsigned C_CNT_WIDTH = 32
) (
  input  logic                   gtx_clk,
  input  logic                   gtx_resetn,
  input  logic [7:0]             gmii_in_rxd,
  input  logic                   gmii_in_rx_dv,
  input  logic                   gmii_in_rx_er,
  input  logic [7:0]             select,
  output logic [7:0]             gmii_out_0_rxd,
  output logic                   gmii_out_0_rx_dv,
  output logic                   gmii_out_0_rx_er,
  output logic [7:0]             gmii_out_1_rxd,
  output logic                   gmii_out_1_rx_dv,
  output logic                   gmii_out_1_rx_er,
  output logic [7:0]             gmii_out_2_rxd,
  output logic                   gmii_out_2_rx_dv,
  output logic                   gmii_out_2_rx_er,
  output logic [C_CNT_WIDTH-1:0] frame_cnt_0,
  output logic [C_CNT_WIDTH-1:0] frame_cnt_1,
  output logic [C_CNT_WIDTH-1:0] frame_cnt_2,
  output logic [C_CNT_WIDTH-1:0] drop_cnt
);

  typedef enum logic {IDLE, FRAME} state_t;

  logic [7:0] rxd_r;
  logic       dv_r;
  logic       er_r;
  logic [7:0] select_r;
  logic       s1_valid;

  state_t     state;
  logic [7:0] act_q;
  logic       wait_q;
  logic [7:0] eff_port;
  logic       frame_start;
  logic [2:0] port_hit;

  always_ff @(posedge gtx_clk) begin
    if (!gtx_resetn) begin
      rxd_r    <= '0;
      dv_r     <= 1'b0;
      er_r     <= 1'b0;
      select_r <= '0;
      s1_valid <= 1'b0;
    end else begin
      rxd_r    <= gmii_in_rxd;
      dv_r     <= gmii_in_rx_dv;
      er_r     <= gmii_in_rx_er;
      select_r <= select;
      s1_valid <= 1'b1;
    end
  end

  always_comb begin
    eff_port = select_r;
    if (state == FRAME) eff_port = act_q;
  end

  assign frame_start = (state == IDLE) && dv_r && !wait_q;

  // wait_q blocks forwarding after reset until a genuinely sampled dv_r = 0
  // is seen, so the tail of a frame cut by reset is never forwarded.
  always_ff @(posedge gtx_clk) begin
    if (!gtx_resetn) begin
      state  <= IDLE;
      act_q  <= '0;
      wait_q <= 1'b1;
    end else begin
      if (wait_q && s1_valid && !dv_r) wait_q <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= FRAME;
            act_q <= select_r;
          end
        end
        FRAME: begin
          if (!dv_r) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    port_hit = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      port_hit[i] = !wait_q && (eff_port == 8'(i));
    end
  end

  always_ff @(posedge gtx_clk) begin
    if (!gtx_resetn) begin
      gmii_out_0_rxd   <= '0;
      gmii_out_0_rx_dv <= 1'b0;
      gmii_out_0_rx_er <= 1'b0;
      gmii_out_1_rxd   <= '0;
      gmii_out_1_rx_dv <= 1'b0;
      gmii_out_1_rx_er <= 1'b0;
      gmii_out_2_rxd   <= '0;
      gmii_out_2_rx_dv <= 1'b0;
      gmii_out_2_rx_er <= 1'b0;
    end else begin
      gmii_out_0_rxd   <= port_hit[0] ? rxd_r : '0;
      gmii_out_0_rx_dv <= port_hit[0] && dv_r;
      gmii_out_0_rx_er <= port_hit[0] && er_r;
      gmii_out_1_rxd   <= port_hit[1] ? rxd_r : '0;
      gmii_out_1_rx_dv <= port_hit[1] && dv_r;
      gmii_out_1_rx_er <= port_hit[1] && er_r;
      gmii_out_2_rxd   <= port_hit[2] ? rxd_r : '0;
      gmii_out_2_rx_dv <= port_hit[2] && dv_r;
      gmii_out_2_rx_er <= port_hit[2] && er_r;
    end
  end

`ifdef GMII_DEMUX_FRAME_CNT_EN
  logic [C_CNT_WIDTH-1:0] cnt_0_q;
  logic [C_CNT_WIDTH-1:0] cnt_1_q;
  logic [C_CNT_WIDTH-1:0] cnt_2_q;
  logic [C_CNT_WIDTH-1:0] drop_q;

  always_ff @(posedge gtx_clk) begin
    if (!gtx_resetn) begin
      cnt_0_q <= '0;
      cnt_1_q <= '0;
      cnt_2_q <= '0;
      drop_q  <= '0;
    end else if (frame_start) begin
      case (select_r)
        8'd0:    cnt_0_q <= cnt_0_q + C_CNT_WIDTH'(1);
        8'd1:    cnt_1_q <= cnt_1_q + C_CNT_WIDTH'(1);
        8'd2:    cnt_2_q <= cnt_2_q + C_CNT_WIDTH'(1);
        default: drop_q  <= drop_q + C_CNT_WIDTH'(1);
      endcase
    end
  end

  assign frame_cnt_0 = cnt_0_q;
  assign frame_cnt_1 = cnt_1_q;
  assign frame_cnt_2 = cnt_2_q;
  assign drop_cnt    = drop_q;
`else
  assign frame_cnt_0 = '0;
  assign frame_cnt_1 = '0;
  assign frame_cnt_2 = '0;
  assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_gmii_demux.sv
// Randomised self-checking bench for gmii_demux against a frame-level reference model.
// Counter expectations follow GMII_DEMUX_FRAME_CNT_EN the same way the design does.
module tb_gmii_demux;

`ifdef GMII_DEMUX_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        gtx_clk = 1'b0;
  logic        gtx_resetn = 1'b0;
  logic [7:0]  gmii_in_rxd = '0;
  logic        gmii_in_rx_dv = 1'b0;
  logic        gmii_in_rx_er = 1'b0;
  logic [7:0]  select = '0;
  logic [7:0]  o0_rxd, o1_rxd, o2_rxd;
  logic        o0_dv, o1_dv, o2_dv, o0_er, o1_er, o2_er;
  logic [31:0] frame_cnt_0, frame_cnt_1, frame_cnt_2, drop_cnt;

  gmii_demux #(.C_CNT_WIDTH(32)) dut (
    .gtx_clk(gtx_clk), .gtx_resetn(gtx_resetn),
    .gmii_in_rxd(gmii_in_rxd), .gmii_in_rx_dv(gmii_in_rx_dv), .gmii_in_rx_er(gmii_in_rx_er),
    .select(select),
    .gmii_out_0_rxd(o0_rxd), .gmii_out_0_rx_dv(o0_dv), .gmii_out_0_rx_er(o0_er),
    .gmii_out_1_rxd(o1_rxd), .gmii_out_1_rx_dv(o1_dv), .gmii_out_1_rx_er(o1_er),
    .gmii_out_2_rxd(o2_rxd), .gmii_out_2_rx_dv(o2_dv), .gmii_out_2_rx_er(o2_er),
    .frame_cnt_0(frame_cnt_0), .frame_cnt_1(frame_cnt_1), .frame_cnt_2(frame_cnt_2),
    .drop_cnt(drop_cnt)
  );

  always #4 gtx_clk = ~gtx_clk;

  typedef struct packed {
    logic       rstn;
    logic       dv;
    logic       er;
    logic [7:0] d;
    logic [7:0] s;
  } stim_t;

  stim_t q[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // Reference model: a frame is a maximal run of dv=1 samples; it goes to
  // the select seen with its first byte. Samples outside frames go to the
  // select of that cycle, except the first dv=0 sample closing a frame.
  logic [9:0]   pend[3] = '{default: '0};
  int           pend_inc = -1;
  logic [31:0]  m_cnt[4] = '{default: '0};
  bit           m_in_frame = 1'b0;
  bit           m_wait = 1'b1;
  logic [7:0]   m_port = '0;
  logic [29:0]  exp_out = '0;
  logic [127:0] exp_cnt = '0;

  wire [29:0]  out_vec = {o0_rxd, o0_dv, o0_er, o1_rxd, o1_dv, o1_er, o2_rxd, o2_dv, o2_er};
  wire [127:0] cnt_vec = {frame_cnt_0, frame_cnt_1, frame_cnt_2, drop_cnt};

  function automatic void push(input logic rstn, input logic dv, input logic er,
                               input logic [7:0] d, input logic [7:0] s);
    q.push_back({rstn, dv, er, d, s});
  endfunction

  function automatic logic [7:0] rand_sel();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 9) return 8'(r % 3);
    return 8'($urandom_range(3, 255));
  endfunction

  task automatic step(input stim_t st);
    logic [7:0] port;
    bit         was;
    @(negedge gtx_clk);
    gtx_resetn    = st.rstn;
    gmii_in_rx_dv = st.dv;
    gmii_in_rx_er = st.er;
    gmii_in_rxd   = st.d;
    select        = st.s;
    @(posedge gtx_clk);
    cyc++;
    if (!st.rstn) begin
      exp_out    = '0;
      pend       = '{default: '0};
      pend_inc   = -1;
      m_cnt      = '{default: '0};
      m_in_frame = 1'b0;
      m_wait     = 1'b1;
    end else begin
      exp_out = {pend[0], pend[1], pend[2]};
      if (pend_inc >= 0) m_cnt[pend_inc] = m_cnt[pend_inc] + 32'd1;
      pend     = '{default: '0};
      pend_inc = -1;
      if (m_wait) begin
        if (!st.dv) m_wait = 1'b0;
      end else begin
        was = m_in_frame;
        if (st.dv && !was) begin
          m_port   = st.s;
          pend_inc = (st.s < 8'd3) ? int'(st.s) : 3;
        end
        port = (was || st.dv) ? m_port : st.s;
        m_in_frame = st.dv;
        if (port < 8'd3) pend[port] = {st.d, st.dv, st.er};
      end
    end
    exp_cnt = CNT_EN ? {m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]} : '0;
    #1;
  endtask

  task automatic idle(input int n, input logic [7:0] s);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0, 8'h00, s);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3, 8'd0);
    while (q.size() > 0) begin
      step(q.pop_front());
      checks++;
      if (out_vec !== exp_out) begin
        errors++; $display("FAIL reset_out cyc=%0d got=%h exp=%h", cyc, out_vec, exp_out);
      end
      checks++;
      if (cnt_vec !== exp_cnt) begin
        errors++; $display("FAIL reset_cnt cyc=%0d got=%h exp=%h", cyc, cnt_vec, exp_cnt);
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 64; i++) push(1'b1, 1'b1, 1'b0, 8'(i), 8'd1);
    idle(4, 8'd1);
    while (q.size() > 0) begin
      step(q.pop_front());
      checks++;
      if (out_vec !== exp_out) begin
        errors++; $display("FAIL basic_out cyc=%0d got=%h exp=%h", cyc, out_vec, exp_out);
      end
      checks++;
      if (cnt_vec !== exp_cnt) begin
        errors++; $display("FAIL basic_cnt cyc=%0d got=%h exp=%h", cyc, cnt_vec, exp_cnt);
      end
    end
  endtask

  task automatic test_select_change();
    for (int i = 0; i < 100; i++) push(1'b1, 1'b1, 1'b0, 8'($urandom), (i < 10) ? 8'd0 : 8'd2);
    idle(1, 8'd2);
    for (int i = 0; i < 20; i++) push(1'b1, 1'b1, 1'b0, 8'($urandom), 8'd2);
    idle(4, 8'd2);
    while (q.size() > 0) begin
      step(q.pop_front());
      checks++;
      if (out_vec !== exp_out) begin
        errors++; $display("FAIL selchg_out cyc=%0d got=%h exp=%h", cyc, out_vec, exp_out);
      end
      checks++;
      if (cnt_vec !== exp_cnt) begin
        errors++; $display("FAIL selchg_cnt cyc=%0d got=%h exp=%h", cyc, cnt_vec, exp_cnt);
      end
    end
  endtask

  task automatic test_invalid_select();
    for (int i = 0; i < 60; i++) push(1'b1, 1'b1, 1'(i == 30), 8'($urandom), 8'd5);
    idle(3, 8'd5);
    idle(2, 8'd0);
    while (q.size() > 0) begin
      step(q.pop_front());
      checks++;
      if (out_vec !== exp_out) begin
        errors++; $display("FAIL invalid_out cyc=%0d got=%h exp=%h", cyc, out_vec, exp_out);
      end
      checks++;
      if (cnt_vec !== exp_cnt) begin
        errors++; $display("FAIL invalid_cnt cyc=%0d got=%h exp=%h", cyc, cnt_vec, exp_cnt);
      end
    end
  endtask

  task automatic test_one_byte();
    push(1'b1, 1'b1, 1'b0, 8'hA5, 8'd0);
    idle(1, 8'd1);
    push(1'b1, 1'b1, 1'b0, 8'h5A, 8'd1);
    // false carrier (er without dv) on port 2, then carrier extension after a frame
    push(1'b1, 1'b0, 1'b1, 8'h0E, 8'd2);
    push(1'b1, 1'b0, 1'b1, 8'h0F, 8'd2);
    idle(3, 8'd2);
    while (q.size() > 0) begin
      step(q.pop_front());
      checks++;
      if (out_vec !== exp_out) begin
        errors++; $display("FAIL onebyte_out cyc=%0d got=%h exp=%h", cyc, out_vec, exp_out);
      end
      checks++;
      if (cnt_vec !== exp_cnt) begin
        errors++; $display("FAIL onebyte_cnt cyc=%0d got=%h exp=%h", cyc, cnt_vec, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    idle(2, 8'd1);
    for (int i = 0; i < 64; i++) push(1'(i != 20), 1'b1, 1'b0, 8'(i), 8'd1);
    idle(2, 8'd1);
    for (int i = 0; i < 16; i++) push(1'b1, 1'b1, 1'b0, 8'(8'h80 + i), 8'd1);
    idle(3, 8'd1);
    while (q.size() > 0) begin
      step(q.pop_front());
      checks++;
      if (out_vec !== exp_out) begin
        errors++; $display("FAIL rstmid_out cyc=%0d got=%h exp=%h", cyc, out_vec, exp_out);
      end
      checks++;
      if (cnt_vec !== exp_cnt) begin
        errors++; $display("FAIL rstmid_cnt cyc=%0d got=%h exp=%h", cyc, cnt_vec, exp_cnt);
      end
    end
  endtask

  task automatic test_counter_wrap();
    idle(2, 8'd0);
    while (q.size() > 0) step(q.pop_front());
`ifdef GMII_DEMUX_FRAME_CNT_EN
    @(negedge gtx_clk);
    force dut.cnt_0_q = '1;
    force dut.cnt_1_q = '1;
    force dut.cnt_2_q = '1;
    force dut.drop_q  = '1;
    #1;
    release dut.cnt_0_q;
    release dut.cnt_1_q;
    release dut.cnt_2_q;
    release dut.drop_q;
    m_cnt = '{default: '1};
`endif
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 5; i++) push(1'b1, 1'b1, 1'b0, 8'($urandom), (p == 3) ? 8'd200 : 8'(p));
      idle(2, 8'd0);
    end
    idle(2, 8'd0);
    while (q.size() > 0) begin
      step(q.pop_front());
      checks++;
      if (out_vec !== exp_out) begin
        errors++; $display("FAIL wrap_out cyc=%0d got=%h exp=%h", cyc, out_vec, exp_out);
      end
      checks++;
      if (cnt_vec !== exp_cnt) begin
        errors++; $display("FAIL wrap_cnt cyc=%0d got=%h exp=%h", cyc, cnt_vec, exp_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] s;
    for (int f = 0; f < 80; f++) begin
      s = rand_sel();
      for (int g = $urandom_range(0, 3); g > 0; g--)
        push(1'b1, 1'b0, 1'($urandom_range(0, 7) == 0), 8'($urandom), rand_sel());
      for (int i = $urandom_range(1, 24); i > 0; i--) begin
        if ($urandom_range(0, 7) == 0) s = rand_sel();
        push(1'($urandom_range(0, 59) != 0), 1'b1, 1'($urandom_range(0, 15) == 0), 8'($urandom), s);
      end
    end
    idle(4, 8'd0);
    while (q.size() > 0) begin
      step(q.pop_front());
      checks++;
      if (out_vec !== exp_out) begin
        errors++; $display("FAIL random_out cyc=%0d got=%h exp=%h", cyc, out_vec, exp_out);
      end
      checks++;
      if (cnt_vec !== exp_cnt) begin
        errors++; $display("FAIL random_cnt cyc=%0d got=%h exp=%h", cyc, cnt_vec, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_select_change();
    test_invalid_select();
    test_one_byte();
    test_reset_mid_frame();
    test_counter_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
